// File: rtl/alu_defs_pkg.sv
// alu_defs: shared state encodings, shift directions and default widths for the shift unit
package alu_defs;
  localparam int WIDTH_DEF = 4;
  localparam int CNTW_DEF = 3;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE = 2'd2;
  localparam logic DIR_LEFT = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
endpackage

// File: rtl/shift_step.sv
// shift_step: single-bit combinational shift with caller-supplied fill bit
module shift_step
  import alu_defs::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIR,
  input  logic             FILL,
  output logic [WIDTH-1:0] OUT,
  output logic             BITOUT
);
  // fill enters at the vacated end; the bit leaving the other end is reported
  always_comb begin
    OUT = (DIR == DIR_RIGHT) ? {FILL, DIN[WIDTH-1:1]} : {DIN[WIDTH-2:0], FILL};
    BITOUT = (DIR == DIR_RIGHT) ? DIN[0] : DIN[WIDTH-1];
  end
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: iterates a 1-bit shift stage AMT times behind valid/ready handshakes
module shift_sequencer
  import alu_defs::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [CNTW-1:0]  AMT,
  input  logic             DIR,
  input  logic             ARITH,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT,
  output logic             C
);
  state_t state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic dir_q, dir_d, arith_q, arith_d, c_q, c_d;
  logic [WIDTH-1:0] step_out;
  logic step_bit, fill;
  // only arithmetic right shifts replicate the sign; everything else fills with zero
  always_comb fill = (dir_q == DIR_RIGHT) && arith_q ? opnd_q[WIDTH-1] : 1'b0;
  shift_step #(.WIDTH(WIDTH)) u_step (
    .DIN(opnd_q),
    .DIR(dir_q),
    .FILL(fill),
    .OUT(step_out),
    .BITOUT(step_bit)
  );
  // next-state: accept in IDLE, one step per SHIFT edge until count hits zero, hold in DONE
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    opnd_d = opnd_q;
    dir_d = dir_q;
    arith_d = arith_q;
    c_d = c_q;
    case (state_q)
      ST_IDLE: if (IN_VALID) begin
        opnd_d = A;
        cnt_d = AMT;
        dir_d = DIR;
        arith_d = ARITH;
        c_d = 1'b0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: if (cnt_q == '0) begin
        state_d = ST_DONE;
      end else begin
        opnd_d = step_out;
        c_d = step_bit;
        cnt_d = cnt_q - CNTW'(1);
      end
      ST_DONE: state_d = OUT_READY ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end
  // state and datapath registers; reset discards any in-flight command
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      opnd_q <= '0;
      dir_q <= 1'b0;
      arith_q <= 1'b0;
      c_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      opnd_q <= opnd_d;
      dir_q <= dir_d;
      arith_q <= arith_d;
      c_q <= c_d;
    end
  end
  // outputs come straight from registers or a state decode
  always_comb begin
    IN_READY = state_q == ST_IDLE;
    OUT_VALID = state_q == ST_DONE;
    OUT = opnd_q;
    C = c_q;
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: table-driven and scoreboarded checks of the multi-cycle shift unit
module tb_shift_sequencer;
  logic CLK = 1'b0, RESETN = 1'b0, IN_VALID = 1'b0, DIR = 1'b0, ARITH = 1'b0, OUT_READY = 1'b1;
  logic [3:0] A = '0;
  logic [2:0] AMT = '0;
  logic IN_READY, OUT_VALID, C;
  logic [3:0] OUT;
  int errors = 0, checks = 0, cyc = 0;
  typedef struct {
    logic [3:0] a;
    logic [2:0] amt;
    logic dir;
    logic arith;
    logic [3:0] out;
    logic c;
  } vec_t;
  typedef struct {
    logic [3:0] out;
    logic c;
    int cyc;
  } exp_t;
  exp_t q[$];
  bit seen = 0;
  vec_t vecs[6];
  shift_sequencer #(.WIDTH(4), .CNTW(3)) dut (
    .CLK(CLK), .RESETN(RESETN), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .AMT(AMT), .DIR(DIR), .ARITH(ARITH),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT(OUT), .C(C)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [3:0] a, input logic [2:0] amt, input logic dir, input logic arith);
    exp_t e;
    logic [11:0] l;
    logic [15:0] r;
    if (dir == 1'b0) begin
      l = {8'b0, a} << amt;
      e.out = l[3:0];
      e.c = (amt == 0) ? 1'b0 : l[4];
    end else begin
      r = {{8{arith & a[3]}}, a, 4'b0} >> amt;
      e.out = r[7:4];
      e.c = (amt == 0) ? 1'b0 : r[3];
    end
    e.cyc = 0;
    return e;
  endfunction
  task automatic send(input logic [3:0] a, input logic [2:0] amt, input logic dir, input logic arith,
                      input logic [3:0] eo, input logic ec);
    exp_t e;
    int n = 0;
    @(negedge CLK);
    IN_VALID = 1'b1; A = a; AMT = amt; DIR = dir; ARITH = arith;
    while (!IN_READY && n < 60) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 60) chk("in_ready_timeout", 0, 1);
    e.out = eo; e.c = ec; e.cyc = cyc + int'(amt) + 2;
    q.push_back(e);
    @(posedge CLK);
    #1 IN_VALID = 1'b0; A = $urandom; AMT = $urandom; DIR = $urandom; ARITH = $urandom;
  endtask
  always @(negedge CLK) begin
    if (RESETN && OUT_VALID) begin
      if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        if (!seen) chk("latency", cyc, q[0].cyc);
        seen = 1;
        if (OUT_READY) begin
          chk("out", OUT, q[0].out);
          chk("c", C, q[0].c);
          void'(q.pop_front());
          seen = 0;
        end
      end
    end
  end
  task automatic drain;
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 0, 1);
    @(negedge CLK);
  endtask
  initial begin
    exp_t e;
    vecs[0] = '{4'b1011, 3'd1, 1'b0, 1'b0, 4'b0110, 1'b1};
    vecs[1] = '{4'b1010, 3'd2, 1'b1, 1'b1, 4'b1110, 1'b1};
    vecs[2] = '{4'b1010, 3'd2, 1'b1, 1'b0, 4'b0010, 1'b1};
    vecs[3] = '{4'b0101, 3'd0, 1'b0, 1'b0, 4'b0101, 1'b0};
    vecs[4] = '{4'b1001, 3'd7, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[5] = '{4'b1001, 3'd7, 1'b1, 1'b1, 4'b1111, 1'b1};
    #12;
    chk("rst_out", OUT, 0);
    chk("rst_c", C, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_in_ready", IN_READY, 1);
    @(negedge CLK) RESETN = 1'b1;
    for (int i = 0; i < 6; i++) send(vecs[i].a, vecs[i].amt, vecs[i].dir, vecs[i].arith, vecs[i].out, vecs[i].c);
    drain();
    send(4'b1011, 3'd3, 1'b0, 1'b0, 4'b1000, 1'b1);
    @(posedge CLK);
    #2 RESETN = 1'b0;
    #1;
    chk("midrst_out", OUT, 0);
    chk("midrst_c", C, 0);
    chk("midrst_out_valid", OUT_VALID, 0);
    chk("midrst_in_ready", IN_READY, 1);
    q.delete();
    seen = 0;
    @(negedge CLK) RESETN = 1'b1;
    send(4'b1011, 3'd1, 1'b0, 1'b0, 4'b0110, 1'b1);
    drain();
    OUT_READY = 1'b0;
    send(4'b1100, 3'd2, 1'b1, 1'b1, 4'b1111, 1'b0);
    begin
      int n = 0;
      while (!OUT_VALID && n < 20) begin
        @(negedge CLK);
        n++;
      end
      if (!OUT_VALID) chk("bp_valid_timeout", 0, 1);
    end
    IN_VALID = 1'b1; A = 4'b0110; AMT = 3'd1; DIR = 1'b1; ARITH = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("bp_out_valid", OUT_VALID, 1);
      chk("bp_out", OUT, 4'b1111);
      chk("bp_c", C, 0);
      chk("bp_in_ready", IN_READY, 0);
    end
    @(posedge CLK);
    #1 OUT_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("rel_out_valid", OUT_VALID, 0);
    chk("rel_in_ready", IN_READY, 1);
    e = model(4'b0110, 3'd1, 1'b1, 1'b0);
    e.cyc = cyc + 3;
    q.push_back(e);
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
    chk("rel_accepted", IN_READY, 0);
    drain();
    for (int i = 0; i < 12; i++) begin
      logic [3:0] a;
      logic [2:0] amt;
      logic dir, arith;
      a = 4'($urandom); amt = 3'($urandom); dir = 1'($urandom); arith = 1'($urandom);
      e = model(a, amt, dir, arith);
      send(a, amt, dir, arith, e.out, e.c);
    end
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle shift unit sitting directly upstream of the ALU result mux. It wraps a single-step 1-bit shift stage and iterates it AMT times on a registered operand, then presents the result and the last shifted-out bit. Operands arrive through a valid/ready handshake from the operand-select stage. Results leave through a valid/ready handshake to the ALU output stage.

Parameters:
WIDTH, 4, operand/result width in bits
CNTW, 3, shift-amount width; maximum amount is 2^CNTW-1

Ports:
CLK  input  1  single clock, rising edge
RESETN  input  1  asynchronous, active-low reset
IN_VALID  input  1  operand/command valid
IN_READY  output  1  unit can accept a command
A  input  WIDTH  operand
AMT  input  CNTW  shift amount, 0..2^CNTW-1
DIR  input  1  0 = left, 1 = right
ARITH  input  1  right shifts only: 1 = fill with sign bit, 0 = fill with zero
OUT_VALID  output  1  result valid
OUT_READY  input  1  downstream accepts result
OUT  output  WIDTH  shifted result
C  output  1  last bit shifted out; 0 when AMT = 0

Behaviour:
- Reset: RESETN = 0 asynchronously forces state IDLE, OUT = 0, C = 0, OUT_VALID = 0, IN_READY = 1, and clears the internal count and operand registers. Takes effect immediately, including mid-operation. The in-flight command is discarded.
- States: IDLE, SHIFT, DONE. Encode them as 2-bit localparams.
- IDLE:
  - IN_READY = 1.
  - On an edge with IN_VALID = 1: latch A, AMT, DIR, ARITH; clear C; go to SHIFT.
- SHIFT:
  - IN_READY = 0.
  - If count = 0: go to DONE.
  - Otherwise, per edge: reg <= step(reg), C <= the bit leaving (reg[WIDTH-1] for left, reg[0] for right), count <= count - 1.
- step():
  - Left: {reg[WIDTH-2:0], 0}.
  - Right logical: {0, reg[WIDTH-1:1]}.
  - Right arithmetic: {reg[WIDTH-1], reg[WIDTH-1:1]}.
  - DIR/ARITH are taken from the latched copies, not the live inputs.
- DONE:
  - OUT_VALID = 1; OUT and C stay stable.
  - On an edge with OUT_READY = 1: go to IDLE, with OUT_VALID low on the following cycle.
  - While OUT_READY = 0: hold OUT_VALID, OUT and C unchanged indefinitely.
- Latency: OUT_VALID rises exactly AMT+2 edges after the accepting edge.
  - AMT = 0: accept edge, SHIFT (count 0), DONE → OUT_VALID visible after the 2nd edge.
- Throughput:
  - No accept in DONE or SHIFT; back-to-back commands are separated by at least one IDLE cycle.
  - IN_VALID during a busy period is ignored. Upstream must hold it until IN_READY.
- Amounts ≥ WIDTH:
  - Iterate the full AMT steps with no early exit.
  - Result is 0 for left shifts and right logical shifts; all sign bits for right arithmetic.
  - C follows the last step (0 for logical, sign bit for arithmetic right).
- OUT is driven from the working register. Between reset and the first DONE it shows intermediate values; consumers use it only when OUT_VALID = 1.
- Simultaneous events: in DONE, an OUT_READY acceptance and a new IN_VALID on the same edge does not accept the new command. It is accepted on the next IDLE edge.
- All outputs are registered or decoded from state only. No combinational path from input to output except none.

Decomposition:
- Shared package/include alu_defs:
  - State localparams.
  - Direction encodings DIR_LEFT = 0, DIR_RIGHT = 1.
  - Default WIDTH.
- One sub-module shift_step: purely combinational, single-bit shift of WIDTH bits with inputs DIR and FILL, outputs OUT and BITOUT. It is instantiated once and its output feeds the working register each SHIFT cycle.
- Control FSM and counter live in shift_sequencer.

Test Plan:
- Reset mid-shift: A = 1011, AMT = 3, DIR = 0; assert RESETN = 0 during the 2nd SHIFT cycle → immediately OUT = 0000, C = 0, OUT_VALID = 0, IN_READY = 1; the next command runs normally.
- Left shift: A = 1011, AMT = 1, DIR = 0 → OUT = 0110, C = 1, OUT_VALID exactly 3 edges after accept.
- Arithmetic right: A = 1010, AMT = 2, DIR = 1, ARITH = 1 → OUT = 1110, C = 1; same with ARITH = 0 → OUT = 0010, C = 1.
- Zero and over-range amounts:
  - AMT = 0, A = 0101 → OUT = 0101, C = 0, latency 2.
  - AMT = 7, A = 1001, left → OUT = 0000, C = 0.
  - AMT = 7, A = 1001, right arithmetic → OUT = 1111, C = 1.
- Backpressure: hold OUT_READY = 0 for 5 cycles in DONE → OUT_VALID/OUT/C stable, IN_READY = 0, IN_VALID ignored; release → OUT_VALID drops next cycle and a pending command is accepted on the following edge.
